// File: rtl/core_decode_stage.sv
// core_decode_stage: RV32I/RV64I decode stage with 2-entry skid buffer and illegal counter.
// Define CORE_DECODE_MEXT_EN to decode M-extension encodings as unit MULDIV instead of illegal.
module core_decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [4:0]       out_rs1_addr,
    output logic [4:0]       out_rs2_addr,
    output logic [4:0]       out_rd_addr,
    output logic             out_rd_we,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_alu_op,
    output logic [1:0]       out_src_a_sel,
    output logic             out_src_b_sel,
    output logic [2:0]       out_unit,
    output logic [2:0]       out_funct3,
    output logic             out_word,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic RV64 = (XLEN == 64);
`ifdef CORE_DECODE_MEXT_EN
    localparam logic MEXT = 1'b1;
`else
    localparam logic MEXT = 1'b0;
`endif
    localparam logic [2:0] U_ALU = 3'd0, U_LSU = 3'd1, U_BR = 3'd2, U_SYS = 3'd3, U_MD = 3'd4;
    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLL = 5'd2, A_SLT = 5'd4, A_SLTU = 5'd5;
    localparam logic [4:0] A_SRL = 5'd6, A_SRA = 5'd7, A_AND = 5'd8, A_OR = 5'd9, A_XOR = 5'd10;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_op;
        logic [1:0]      src_a;
        logic            src_b;
        logic [2:0]      unit;
        logic [2:0]      funct3;
        logic            word;
        logic            illegal;
    } bundle_t;

    // funct3 to ALU op for register/immediate arithmetic; alt selects SUB/SRA
    function automatic logic [4:0] alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? A_SUB : A_ADD;
            3'b001:  return A_SLL;
            3'b010:  return A_SLT;
            3'b011:  return A_SLTU;
            3'b100:  return A_XOR;
            3'b101:  return alt ? A_SRA : A_SRL;
            3'b110:  return A_OR;
            default: return A_AND;
        endcase
    endfunction

    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            sh_ok, legal, wr, is_md;
    logic            accept, xfer;
    bundle_t         dec, m_d, m_q, s_d, s_q;
    logic            m_valid_d, m_valid_q, s_valid_d, s_valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign imm_i = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
    assign imm_s = {{(XLEN-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
    assign imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    // immediate shifts: bits above shamt must be zero, or the single SRAI marker bit
    assign sh_ok = RV64 ? (in_inst[31:26] == 6'h00 || (f3 == 3'b101 && in_inst[31:26] == 6'h10))
                        : (in_inst[31:25] == 7'h00 || (f3 == 3'b101 && in_inst[31:25] == 7'h20));

    assign in_ready = !s_valid_q;
    assign accept   = in_valid && in_ready;
    assign xfer     = m_valid_q && out_ready;

    // combinational decode of the incoming instruction into a bundle
    always_comb begin
        dec = '0;
        dec.pc = in_pc;
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];
        dec.rd = in_inst[11:7];
        dec.funct3 = f3;
        legal = 1'b0;
        wr = 1'b1;
        is_md = 1'b0;
        case (in_inst[6:0])
            7'h03: begin
                legal = f3 != 3'b111 && (RV64 || (f3 != 3'b011 && f3 != 3'b110));
                dec.unit = U_LSU;
                dec.src_b = 1'b1;
                dec.imm = imm_i;
            end
            7'h0f: begin
                legal = f3 == 3'b000;
                wr = 1'b0;
                dec.unit = U_SYS;
            end
            7'h13: begin
                legal = (f3 != 3'b001 && f3 != 3'b101) || sh_ok;
                dec.alu_op = alu_sel(f3, f3 == 3'b101 && in_inst[30]);
                dec.src_b = 1'b1;
                dec.imm = imm_i;
            end
            7'h1b: begin
                legal = RV64 && (f3 == 3'b000 || (f3 == 3'b001 && f7 == 7'h00) ||
                                 (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)));
                dec.alu_op = alu_sel(f3, f3 == 3'b101 && in_inst[30]);
                dec.src_b = 1'b1;
                dec.imm = imm_i;
                dec.word = 1'b1;
            end
            7'h17: begin
                legal = 1'b1;
                dec.src_a = 2'd1;
                dec.src_b = 1'b1;
                dec.imm = imm_u;
            end
            7'h23: begin
                legal = f3 < (RV64 ? 3'd4 : 3'd3);
                wr = 1'b0;
                dec.unit = U_LSU;
                dec.src_b = 1'b1;
                dec.imm = imm_s;
            end
            7'h33: begin
                is_md = MEXT && f7 == 7'h01;
                legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || is_md;
                dec.unit = is_md ? U_MD : U_ALU;
                dec.alu_op = is_md ? A_ADD : alu_sel(f3, in_inst[30]);
            end
            7'h37: begin
                legal = 1'b1;
                dec.src_a = 2'd2;
                dec.src_b = 1'b1;
                dec.imm = imm_u;
            end
            7'h3b: begin
                is_md = MEXT && f7 == 7'h01 && (f3 == 3'b000 || f3[2]);
                legal = RV64 && ((f7 == 7'h00 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                                 (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || is_md);
                dec.unit = is_md ? U_MD : U_ALU;
                dec.alu_op = is_md ? A_ADD : alu_sel(f3, in_inst[30]);
                dec.word = 1'b1;
            end
            7'h63: begin
                legal = f3 != 3'b010 && f3 != 3'b011;
                wr = 1'b0;
                dec.unit = U_BR;
                dec.alu_op = !f3[2] ? A_SUB : (f3[1] ? A_SLTU : A_SLT);
                dec.imm = imm_b;
            end
            7'h67: begin
                legal = f3 == 3'b000;
                dec.unit = U_BR;
                dec.src_b = 1'b1;
                dec.imm = imm_i;
            end
            7'h6f: begin
                legal = 1'b1;
                dec.unit = U_BR;
                dec.src_a = 2'd1;
                dec.src_b = 1'b1;
                dec.imm = imm_j;
            end
            7'h73: begin
                legal = f3 != 3'b100;
                dec.unit = U_SYS;
                dec.src_b = 1'b1;
                dec.imm = imm_i;
            end
            default: legal = 1'b0;
        endcase
        dec.illegal = !legal || in_inst[1:0] != 2'b11 || in_inst == '0 || in_inst == '1;
        dec.rd_we = wr && !dec.illegal && dec.rd != 5'd0;
        if (dec.illegal) begin
            dec.unit = U_SYS;
            dec.imm = '0;
            dec.alu_op = A_ADD;
            dec.src_a = 2'd0;
            dec.src_b = 1'b0;
            dec.word = 1'b0;
        end
    end

    // skid buffer steering and illegal counter; flush overrides everything
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_d = m_q;
        s_d = s_q;
        cnt_d = cnt_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            if (xfer && m_q.illegal && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
            if (xfer || !m_valid_q) begin
                m_valid_d = s_valid_q || accept;
                m_d = s_valid_q ? s_q : (accept ? dec : m_q);
                s_valid_d = 1'b0;
            end else if (accept) begin
                s_valid_d = 1'b1;
                s_d = dec;
            end
        end
    end

    // state registers with asynchronous reset clearing data as well as valids
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_q <= '0;
            s_q <= '0;
            cnt_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_q <= m_d;
            s_q <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid     = m_valid_q;
    assign out_pc        = m_q.pc;
    assign out_rs1_addr  = m_q.rs1;
    assign out_rs2_addr  = m_q.rs2;
    assign out_rd_addr   = m_q.rd;
    assign out_rd_we     = m_q.rd_we;
    assign out_imm       = m_q.imm;
    assign out_alu_op    = m_q.alu_op;
    assign out_src_a_sel = m_q.src_a;
    assign out_src_b_sel = m_q.src_b;
    assign out_unit      = m_q.unit;
    assign out_funct3    = m_q.funct3;
    assign out_word      = m_q.word;
    assign out_illegal   = m_q.illegal;
    assign illegal_cnt   = cnt_q;
endmodule

// File: tb/tb_core_decode_stage.sv
// tb_core_decode_stage: scoreboard bench for core_decode_stage with a behavioural decode model.
module tb_core_decode_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam bit RV64 = (XLEN == 64);
`ifdef CORE_DECODE_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [4:0] out_rs1_addr, out_rs2_addr, out_rd_addr, out_alu_op;
    logic out_rd_we, out_src_b_sel, out_word, out_illegal;
    logic [XLEN-1:0] out_imm;
    logic [1:0] out_src_a_sel;
    logic [2:0] out_unit, out_funct3;
    logic [CNT_W-1:0] illegal_cnt;

    core_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
        .out_rd_we(out_rd_we), .out_imm(out_imm), .out_alu_op(out_alu_op),
        .out_src_a_sel(out_src_a_sel), .out_src_b_sel(out_src_b_sel), .out_unit(out_unit),
        .out_funct3(out_funct3), .out_word(out_word), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [4:0] rs1, rs2, rd, alu;
        logic rd_we, sb, word, ill;
        logic [XLEN-1:0] imm;
        logic [1:0] sa;
        logic [2:0] unit, f3;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int cnt_exp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] arith(input logic [2:0] f3, input logic sub, input logic sra);
        logic [39:0] tab = {5'd8, 5'd9, 5'd6, 5'd10, 5'd5, 5'd4, 5'd2, 5'd0};
        if (f3 == 3'd0 && sub) return 5'd1;
        if (f3 == 3'd5 && sra) return 5'd7;
        return tab[int'(f3)*5 +: 5];
    endfunction

    // reference decode straight from the ISA rules
    function automatic exp_t model(input logic [31:0] i, input logic [PC_W-1:0] pc);
        exp_t e;
        logic signed [63:0] s;
        logic [63:0] sg, imm;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic ok, wr, md, alt, sh_ok;
        int shw;
        logic [11:0] upper;
        s = $signed(i);
        sg = s >>> 31;
        op = i[6:0];
        f7 = i[31:25];
        f3 = i[14:12];
        alt = f7 == 7'h20;
        shw = RV64 ? 6 : 5;
        upper = i[31:20] >> shw;
        sh_ok = upper == 0 || (f3 == 3'd5 && upper == 12'(1 << (10 - shw)));
        ok = 1'b1; wr = 1'b1; md = 1'b0; imm = '0;
        e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = f3;
        e.alu = 0; e.sa = 0; e.sb = 1; e.unit = 0; e.word = 0;
        case (op)
            7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} || (RV64 && f3 inside {3'd3, 3'd6});
                   e.unit = 1; imm = s >>> 20; end
            7'h0f: begin ok = f3 == 0; wr = 0; e.unit = 3; e.sb = 0; end
            7'h13: begin ok = !(f3 inside {3'd1, 3'd5}) || sh_ok; e.alu = arith(f3, 0, i[30]); imm = s >>> 20; end
            7'h1b: begin ok = RV64 && (f3 == 0 || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || alt)));
                   e.alu = arith(f3, 0, i[30]); e.word = 1; imm = s >>> 20; end
            7'h17: begin e.sa = 1; imm = (sg << 31) + i[30:12] * 4096; end
            7'h23: begin ok = f3 < (RV64 ? 4 : 3); wr = 0; e.unit = 1; imm = (sg << 11) + i[30:25] * 32 + i[11:7]; end
            7'h33: begin md = MEXT && f7 == 1; ok = f7 == 0 || (alt && f3 inside {3'd0, 3'd5}) || md;
                   e.sb = 0; e.unit = md ? 4 : 0; e.alu = md ? 5'd0 : arith(f3, alt, alt); end
            7'h37: begin e.sa = 2; imm = (sg << 31) + i[30:12] * 4096; end
            7'h3b: begin md = MEXT && f7 == 1 && f3 inside {3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
                   ok = RV64 && ((f7 == 0 && f3 inside {3'd0, 3'd1, 3'd5}) || (alt && f3 inside {3'd0, 3'd5}) || md);
                   e.sb = 0; e.word = 1; e.unit = md ? 4 : 0; e.alu = md ? 5'd0 : arith(f3, alt, alt); end
            7'h63: begin ok = !(f3 inside {3'd2, 3'd3}); wr = 0; e.unit = 2; e.sb = 0;
                   e.alu = f3 < 2 ? 5'd1 : (f3 < 6 ? 5'd4 : 5'd5);
                   imm = (sg << 12) + i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2; end
            7'h67: begin ok = f3 == 0; e.unit = 2; imm = s >>> 20; end
            7'h6f: begin e.sa = 1; e.unit = 2; imm = (sg << 20) + i[19:12] * 4096 + i[20] * 2048 + i[30:21] * 2; end
            7'h73: begin ok = f3 != 4; e.unit = 3; imm = s >>> 20; end
            default: ok = 1'b0;
        endcase
        e.ill = !ok || i == 0 || i == 32'hffffffff || i[1:0] != 2'b11;
        e.rd_we = wr && !e.ill && e.rd != 0;
        if (e.ill) e.unit = 3;
        e.imm = imm[XLEN-1:0];
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: w[6:0] = 7'h03;  1: w[6:0] = 7'h0f;  2: w[6:0] = 7'h13;  3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h1b;  5: w[6:0] = 7'h23;  6: w[6:0] = 7'h33;  7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h3b;  9: w[6:0] = 7'h63;  10: w[6:0] = 7'h67; 11: w[6:0] = 7'h6f;
            12: w[6:0] = 7'h73; default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        if (k == 14) w = '0;
        if (k == 15) w = '1;
        return w;
    endfunction

    // monitor: checks occupancy, counter and the head beat every cycle, pops on transfer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt_exp = 0;
                continue;
            end
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("illegal_cnt", illegal_cnt, cnt_exp);
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                chk("pc", out_pc, e.pc);
                chk("illegal", out_illegal, e.ill);
                chk("unit", out_unit, e.unit);
                chk("rd_we", out_rd_we, e.rd_we);
                chk("rs1", out_rs1_addr, e.rs1);
                chk("rs2", out_rs2_addr, e.rs2);
                chk("rd", out_rd_addr, e.rd);
                chk("funct3", out_funct3, e.f3);
                if (!e.ill) begin
                    chk("imm", out_imm, e.imm);
                    chk("alu_op", out_alu_op, e.alu);
                    chk("src_a", out_src_a_sel, e.sa);
                    chk("src_b", out_src_b_sel, e.sb);
                    chk("word", out_word, e.word);
                end
                if (out_ready && !flush) begin
                    void'(exp_q.pop_front());
                    if (e.ill && cnt_exp != CNT_MAX) cnt_exp++;
                end
            end
        end
    end

    // record what the coming edge does to the pipeline, then advance one cycle
    task automatic step();
        @(negedge clk);
        #1;
        if (rst || flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(model(in_inst, in_pc));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic rdy);
        in_valid = v;
        in_inst = inst;
        in_pc = $urandom;
        out_ready = rdy;
    endtask

    task automatic reset_check();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pc", out_pc, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_rd_we", out_rd_we, 0);
        chk("rst_cnt", illegal_cnt, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_check();
        rst = 1'b0;
        // ADDI x1,x0,5 with one-cycle latency
        drive(1, 32'h00500093, 1);
        step();
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", out_rd_addr, 1);
        chk("addi_rs1", out_rs1_addr, 0);
        chk("addi_imm", out_imm, 5);
        chk("addi_alu", out_alu_op, 0);
        chk("addi_srcb", out_src_b_sel, 1);
        chk("addi_we", out_rd_we, 1);
        chk("addi_unit", out_unit, 0);
        // SW x2,-4(x3)
        drive(1, 32'hFE21AE23, 1);
        step();
        chk("sw_imm", out_imm, 32'hFFFFFFFC);
        chk("sw_rs1", out_rs1_addr, 3);
        chk("sw_rs2", out_rs2_addr, 2);
        chk("sw_unit", out_unit, 1);
        chk("sw_we", out_rd_we, 0);
        chk("sw_ill", out_illegal, 0);
        drive(0, 0, 1);
        step();
        // skid: two beats fill M and S while stalled, third is held off
        drive(1, 32'h00500093, 0);
        step();
        drive(1, 32'h002081B3, 0);
        step();
        chk("skid_full", in_ready, 0);
        drive(1, 32'h123452B7, 0);
        step();
        chk("skid_hold", in_ready, 0);
        drive(1, 32'h123452B7, 1);
        step();
        chk("skid_gap1", out_valid, 1);
        step();
        chk("skid_gap2", out_valid, 1);
        drive(0, 0, 1);
        step();
        chk("skid_drained", out_valid, 0);
        // illegal words and counter saturation
        drive(1, 32'h0, 1);
        step();
        chk("zero_ill", out_illegal, 1);
        chk("zero_we", out_rd_we, 0);
        drive(1, 32'hFFFFFFFF, 1);
        step();
        chk("ones_ill", out_illegal, 1);
        drive(0, 0, 1);
        step();
        chk("cnt_two", illegal_cnt, 2);
        for (int n = 0; n < 20; n++) begin
            drive(1, 32'h0, 1);
            step();
        end
        drive(0, 0, 1);
        step();
        chk("cnt_sat", illegal_cnt, CNT_MAX);
        rst = 1'b1;
        #1;
        reset_check();
        step();
        rst = 1'b0;
        // flush with M and S holding illegal beats, transfer and accept offered too
        drive(1, 32'h0, 0);
        step();
        drive(1, 32'hFFFFFFFF, 0);
        step();
        chk("flush_full", in_ready, 0);
        flush = 1'b1;
        drive(1, 32'h00500093, 1);
        step();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_cnt", illegal_cnt, 0);
        // flush consumes and discards the offered beat
        drive(1, 32'h00500093, 0);
        step();
        flush = 1'b1;
        drive(1, 32'hFE21AE23, 1);
        step();
        flush = 1'b0;
        drive(0, 0, 1);
        step();
        chk("flush_gone", out_valid, 0);
        // MUL x5,x6,x7
        drive(1, 32'h027302B3, 1);
        step();
        chk("mul_rd", out_rd_addr, 5);
`ifdef CORE_DECODE_MEXT_EN
        chk("mul_unit", out_unit, 4);
        chk("mul_ill", out_illegal, 0);
        chk("mul_we", out_rd_we, 1);
`else
        chk("mul_ill", out_illegal, 1);
        chk("mul_we", out_rd_we, 0);
`endif
        // randomized traffic with flushes and one mid-stream reset
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) < 7, gen(), $urandom_range(0, 9) < 6);
            flush = $urandom_range(0, 49) == 0;
            if (n == 1500) begin
                rst = 1'b1;
                #1;
                chk("mid_rst_valid", out_valid, 0);
                chk("mid_rst_ready", in_ready, 1);
                step();
                rst = 1'b0;
            end
            step();
        end
        flush = 1'b0;
        drive(0, 0, 1);
        repeat (4) step();
        chk("drain_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_decode_stage.md
# core_decode_stage

Parametrised, pipelined RV32I/RV64I instruction decode stage between fetch and register-read/issue. Accepts one instruction word and PC per cycle over a valid/ready handshake and emits a registered decoded bundle: register addresses, sign-extended immediate, ALU operation, operand selects, execution-unit select and illegal flag. A 2-entry skid buffer fully decouples upstream `in_ready` from downstream `out_ready`. A saturating illegal-instruction counter is provided for debug.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; 64 enables RV64I W-ops and 6-bit shamt.
- `PC_W`, 32: PC width.
- `CNT_W`, 16: illegal-counter width.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: drop all buffered and incoming instructions.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `in_inst` in 32: instruction word.
- `in_pc` in PC_W: instruction PC.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_pc` out PC_W: PC of decoded instruction.
- `out_rs1_addr`, `out_rs2_addr`, `out_rd_addr` out 5: register addresses.
- `out_rd_we` out 1: register write enable.
- `out_imm` out XLEN: sign-extended immediate.
- `out_alu_op` out 5: ADD=0, SUB=1, SLL=2, SLT=4, SLTU=5, SRL=6, SRA=7, AND=8, OR=9, XOR=10; 3 reserved.
- `out_src_a_sel` out 2: 0 reg rs1, 1 PC, 2 zero.
- `out_src_b_sel` out 1: 0 reg rs2, 1 imm.
- `out_unit` out 3: 0 ALU, 1 LSU, 2 BRANCH, 3 SYSTEM, 4 MULDIV.
- `out_funct3` out 3: raw funct3.
- `out_word` out 1: RV64 W-op (32-bit result, sign-extend).
- `out_illegal` out 1: illegal encoding.
- `illegal_cnt` out CNT_W: saturating count of illegal instructions delivered.

## Operation
- Decode is combinational on `in_inst`; result captured into main register (M) on accept (`in_valid && in_ready`).
- Skid: if M holds valid data and `out_ready`=0 at accept, the beat goes to skid register (S). `in_ready = !S_valid`.
- On downstream transfer (`out_valid && out_ready`): S moves to M if S valid; else M is loaded by a same-cycle accept or goes invalid.
- Order strictly preserved; no beat lost or duplicated.
- Immediates by opcode: I (LOAD, OP_IMM, JALR, SYSTEM), S (STORE), B (BRANCH), U (LUI, AUIPC), J (JAL); all sign-extended from bit 31 to XLEN.
- LUI: src_a zero, src_b imm, ADD. AUIPC: src_a PC, src_b imm, ADD. JAL/JALR/BRANCH: unit BRANCH, rd_we only for JAL/JALR. LOAD/STORE: unit LSU, ADD on rs1+imm.
- OP: funct7 0x00 or 0x20 (0x20 only with funct3 000/101). OP_IMM shifts: imm[11:6]/[11:5] per XLEN must be 0 or 0x10/0x20 (SRAI).
- `out_rd_we` forced 0 when rd=0, for STORE/BRANCH/MISC_MEM, or when illegal.
- Illegal: `inst[1:0]`≠2'b11, unknown opcode, reserved funct3/funct7, all-zero, all-ones word; for XLEN=32 also opcodes 0x1b/0x3b and shamt bit 25 set. Illegal beats still delivered: unit SYSTEM, rd_we 0, illegal 1.
- `illegal_cnt` increments on each downstream transfer with `out_illegal`=1; saturates at all-ones.

## Timing
- Latency: accept in cycle N → `out_valid` in N+1.
- Full throughput 1/cycle with `out_ready` held high.
- Outputs held stable while `out_valid && !out_ready`.
- `flush`: M_valid and S_valid cleared next cycle; beat offered in flush cycle consumed and discarded; `in_ready`=1 in the cycle after flush. Flush dominates simultaneous transfer/accept; counter not incremented for flushed beats.
- Reset (any time, mid-stream included): M_valid=S_valid=0, `out_valid`=0, `in_ready`=1, all data outputs 0, `illegal_cnt`=0.

## Configuration
- `CORE_DECODE_MEXT_EN` defined: OP with funct7 0x01 (and OP_32 with 0x01 when XLEN=64, funct3 000/100–111) decoded as unit MULDIV, src reg/reg, rd_we per rd, not illegal.
- Undefined: those encodings flagged illegal; no MULDIV unit code emitted.

## Test plan
- ADDI x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op=0, src_b=1, rd_we=1, unit=0.
- SW x2,-4(x3) (0xFE21AE23) → imm=0xFFFFFFFC, rs1=3, rs2=2, unit=1, rd_we=0, illegal=0.
- out_ready=0, three consecutive in_valid beats → first two accepted, in_ready=0 on third; out_ready=1 → all three delivered in order, no gaps after skid drains.
- 0x00000000 then 0xFFFFFFFF → both out_illegal=1, rd_we=0; illegal_cnt=2; counter saturates after 2^CNT_W−1 illegals.
- M and S full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1; flushed beats never appear; illegal_cnt unchanged.
- MUL x5,x6,x7 (0x027302B3) → with CORE_DECODE_MEXT_EN: unit=4, rd=5, illegal=0; without: illegal=1, rd_we=0.
